x25519_seq_ctrl: RTL and testbench

//  Operation sequencer between the SIPO operand bank and the X25519 scalar-mult core.
//  - Captures one scalar/u-coordinate pair on a start pulse.
//  - Applies RFC 7748 clamping and u-masking, then launches the core by releasing its reset.
//  - Waits for core valid, bounded by a timeout, and latches the result for the PISO.
//  - Drives busy/valid status for the bus interface.

---
 rtl/x25519_seq_ctrl_if.sv | 35 +++
 rtl/x25519_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_x25519_seq_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/x25519_seq_ctrl_if.sv
// x25519_seq_ctrl_if: bundles the bus-side request/status signals and the
// core-side operand/result signals of the X25519 operation sequencer.
//   slave  : the sequencer itself
//   master : whoever drives requests and models the core (bank, PISO, core)
interface x25519_seq_ctrl_if #(
   parameter int BIT_LENGTH = 256
);
   // bus side
   logic                  start;
   logic [BIT_LENGTH-1:0] scalar_in;
   logic [BIT_LENGTH-1:0] u_in;
   logic [BIT_LENGTH-1:0] point_out;
   logic                  busy;
   logic                  valid;
   logic                  timeout;
   logic                  err_zero;
   // core side
   logic                  core_rst;
   logic [BIT_LENGTH-1:0] core_scalar;
   logic [BIT_LENGTH-1:0] core_point;
   logic [BIT_LENGTH-1:0] core_point_out;
   logic                  core_valid;

   modport slave (
      input  start, scalar_in, u_in, core_point_out, core_valid,
      output point_out, busy, valid, timeout, err_zero,
             core_rst, core_scalar, core_point
   );

   modport master (
      output start, scalar_in, u_in, core_point_out, core_valid,
      input  point_out, busy, valid, timeout, err_zero,
             core_rst, core_scalar, core_point
   );
endinterface

// File: rtl/x25519_seq_ctrl.sv
// x25519_seq_ctrl: sequencer between the SIPO operand bank and the X25519
// scalar-mult core. Captures one scalar/u pair on start, clamps/masks them,
// releases the core from reset, waits (bounded) for core_valid and latches
// the result for the PISO.
// Optional feature macro: X25519_ZERO_CHECK_EN (all-zero result flag).
//
// Handshake semantics:
//   start is a request sampled only in IDLE; a start seen while busy is
//   dropped, never queued. valid is a sticky level: it rises together with
//   the entry into DONE and stays high until the next accepted start, which
//   also clears timeout and err_zero. core_valid is only honoured in RUN.
module x25519_seq_ctrl #(
   parameter int BIT_LENGTH     = 256,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int CNT_W          = 20
) (
   input  logic               clk,
   input  logic               rst,
   x25519_seq_ctrl_if.slave   bus,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] run_cnt;
   logic             accept;
   logic             finish_ok;
   logic             finish_to;
   logic             result_zero;

   assign state_dbg = state;

`ifdef X25519_ZERO_CHECK_EN
   assign result_zero = (bus.core_point_out == '0);
`else
   assign result_zero = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish_ok  = 1'b0;
      finish_to  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = S_ARM;
            end
         end
         S_ARM: begin
            state_next = S_RUN;
         end
         S_RUN: begin
            // core_valid takes priority over the timeout limit
            if (bus.core_valid) begin
               finish_ok  = 1'b1;
               state_next = S_DONE;
            end else if (run_cnt == CNT_LAST) begin
               finish_to  = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Core reset and busy are registered from the next state so they change
   // cleanly with the state transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.core_rst <= 1'b1;
         bus.busy     <= 1'b0;
      end else begin
         bus.core_rst <= (state_next != S_RUN);
         bus.busy     <= (state_next == S_ARM) || (state_next == S_RUN);
      end
   end

   // Operand capture with RFC 7748 clamping of k and masking of u.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.core_scalar <= '0;
         bus.core_point  <= '0;
      end else if (accept) begin
         bus.core_scalar <= {2'b01, bus.scalar_in[BIT_LENGTH-3:3], 3'b000};
         bus.core_point  <= {1'b0, bus.u_in[BIT_LENGTH-2:0]};
      end
   end

   // RUN cycle counter: cleared on accept (so it reads 0 in ARM), counts in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt <= '0;
      end else if (accept) begin
         run_cnt <= '0;
      end else if (state == S_RUN) begin
         run_cnt <= run_cnt + CNT_W'(1);
      end
   end

   // Result latch and sticky status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.point_out <= '0;
         bus.valid     <= 1'b0;
         bus.timeout   <= 1'b0;
         bus.err_zero  <= 1'b0;
      end else if (accept) begin
         bus.valid    <= 1'b0;
         bus.timeout  <= 1'b0;
         bus.err_zero <= 1'b0;
      end else if (finish_ok) begin
         bus.point_out <= bus.core_point_out;
         bus.valid     <= 1'b1;
         bus.timeout   <= 1'b0;
         bus.err_zero  <= result_zero;
      end else if (finish_to) begin
         bus.point_out <= '0;
         bus.valid     <= 1'b1;
         bus.timeout   <= 1'b1;
         bus.err_zero  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_x25519_seq_ctrl.sv
// tb_x25519_seq_ctrl: self-checking bench for x25519_seq_ctrl. The core is a
// stub driven by the bench; expectations come from an arithmetic model of
// clamping/masking and a run-length model of completion vs. timeout.
module tb_x25519_seq_ctrl;

   localparam int T  = 16;
   localparam int CW = 5;
`ifdef X25519_ZERO_CHECK_EN
   localparam bit ZCHK = 1'b1;
`else
   localparam bit ZCHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] state_dbg;
   int         total = 0;
   int         bad   = 0;
   logic [255:0] exp_q[$];
   logic [255:0] last_point = '0;

   x25519_seq_ctrl_if bus ();

   x25519_seq_ctrl #(
      .BIT_LENGTH(256), .TIMEOUT_CYCLES(T), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .state_dbg(state_dbg)
   );

   // clock and reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   // k clamped: drop bits 255/254, drop the residue mod 8, add 2^254
   function automatic logic [255:0] model_clamp(input logic [255:0] k);
      logic [255:0] p254;
      p254 = 256'd1 << 254;
      return (k % p254) - (k % 256'd8) + p254;
   endfunction

   function automatic logic [255:0] model_mask(input logic [255:0] u);
      logic [255:0] p255;
      p255 = 256'd1 << 255;
      return u % p255;
   endfunction

   // One operation; the stub core raises core_valid at the end of RUN cycle
   // `lat` (1-based). lat > T means the core never answers.
   task automatic run_op(input logic [255:0] k, input logic [255:0] u,
                         input logic [255:0] res, input int lat, input bit poke);
      logic [255:0] ek, eu, got_exp;
      bit exp_to, exp_z, done;
      ek = model_clamp(k);
      eu = model_mask(u);
      exp_to = (lat > T);
      exp_q.push_back(exp_to ? 256'd0 : res);
      exp_z = ZCHK && !exp_to && (res == 256'd0);
      done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.scalar_in = k; bus.u_in = u;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.scalar_in = rand256(); bus.u_in = rand256();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL arm_busy got=%0b exp=1", bus.busy); end
      total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL arm_core_rst got=%0b exp=1", bus.core_rst); end
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL arm_valid_clear got=%0b exp=0", bus.valid); end
      total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL arm_timeout_clear got=%0b exp=0", bus.timeout); end
      total++; if (bus.err_zero !== 1'b0) begin bad++; $display("FAIL arm_err_zero_clear got=%0b exp=0", bus.err_zero); end
      @(posedge clk); #1;
      total++; if (bus.core_rst !== 1'b0) begin bad++; $display("FAIL run_core_rst got=%0b exp=0", bus.core_rst); end
      total++; if (bus.core_scalar !== ek) begin bad++; $display("FAIL core_scalar got=%h exp=%h", bus.core_scalar, ek); end
      total++; if (bus.core_point !== eu) begin bad++; $display("FAIL core_point got=%h exp=%h", bus.core_point, eu); end
      for (int i = 1; i <= T + 2 && !done; i++) begin
         if (i == lat) begin
            bus.core_valid = 1'b1; bus.core_point_out = res;
         end else begin
            bus.core_point_out = rand256();
         end
         if (poke && i == 3) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.core_valid = 1'b0; bus.start = 1'b0;
         if (i == lat || i == T) begin
            done = 1'b1;
            got_exp = exp_q.pop_front();
            last_point = got_exp;
            total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL done_valid cyc=%0d got=%0b exp=1", i, bus.valid); end
            total++; if (bus.timeout !== exp_to) begin bad++; $display("FAIL done_timeout got=%0b exp=%0b", bus.timeout, exp_to); end
            total++; if (bus.point_out !== got_exp) begin bad++; $display("FAIL point_out got=%h exp=%h", bus.point_out, got_exp); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%0b exp=0", bus.busy); end
            total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL done_core_rst got=%0b exp=1", bus.core_rst); end
            total++; if (bus.err_zero !== exp_z) begin bad++; $display("FAIL err_zero got=%0b exp=%0b", bus.err_zero, exp_z); end
         end else begin
            total++; if (bus.valid !== 1'b0 || bus.busy !== 1'b1 || bus.core_rst !== 1'b0) begin
               bad++; $display("FAIL run_status cyc=%0d got v=%0b b=%0b cr=%0b exp v=0 b=1 cr=0",
                               i, bus.valid, bus.busy, bus.core_rst);
            end
         end
      end
      total++; if (!done) begin bad++; $display("FAIL run_bound got=no_done exp=done_by_%0d", T); end
      // back in IDLE: a start seen while busy must not have been queued
      repeat (2) begin
         @(posedge clk); #1;
         total++; if (bus.busy !== 1'b0 || bus.valid !== 1'b1 || bus.core_rst !== 1'b1) begin
            bad++; $display("FAIL idle_after_op got b=%0b v=%0b cr=%0b exp b=0 v=1 cr=1",
                            bus.busy, bus.valid, bus.core_rst);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.core_rst !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0 ||
                   bus.timeout !== 1'b0 || bus.err_zero !== 1'b0) begin
         bad++; $display("FAIL reset_flags got cr=%0b b=%0b v=%0b to=%0b ez=%0b state=%0d exp cr=1 others=0",
                         bus.core_rst, bus.busy, bus.valid, bus.timeout, bus.err_zero, state_dbg);
      end
      total++; if (bus.point_out !== '0 || bus.core_scalar !== '0 || bus.core_point !== '0) begin
         bad++; $display("FAIL reset_data got po=%h cs=%h cp=%h exp=0", bus.point_out, bus.core_scalar, bus.core_point);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_rfc_vector();
      run_op(256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4,
             256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c,
             256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552, 7, 1'b0);
   endtask

   task automatic test_clamp();
      run_op({256{1'b1}}, {256{1'b1}}, rand256(), 3, 1'b0);
   endtask

   task automatic test_latency();
      run_op(rand256(), rand256(), rand256(), 5, 1'b0);
      run_op(rand256(), rand256(), rand256(), 1, 1'b0);
   endtask

   task automatic test_timeout();
      run_op(rand256(), rand256(), rand256(), T + 5, 1'b1);
   endtask

   task automatic test_coincide();
      run_op(rand256(), rand256(), rand256(), T, 1'b0);
   endtask

   task automatic test_zero_result();
      run_op(rand256(), rand256(), 256'd0, 4, 1'b0);
   endtask

   task automatic test_ignore_core_valid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.core_valid = 1'b1; bus.core_point_out = rand256();
         @(posedge clk); #1;
         total++; if (bus.point_out !== last_point || bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL idle_core_valid got po=%h v=%0b b=%0b exp po=%h v=1 b=0",
                            bus.point_out, bus.valid, bus.busy, last_point);
         end
      end
      bus.core_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      bus.start = 1'b1; bus.scalar_in = rand256(); bus.u_in = rand256();
      @(negedge clk); bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (bus.core_rst !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.point_out !== '0) begin
         bad++; $display("FAIL async_reset got cr=%0b b=%0b v=%0b po=%h exp cr=1 b=0 v=0 po=0",
                         bus.core_rst, bus.busy, bus.valid, bus.point_out);
      end
      @(negedge clk); rst = 1'b0;
      run_op(rand256(), rand256(), rand256(), 6, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 8; n++) begin
         run_op(rand256(), rand256(), rand256(), $urandom_range(T + 3, 1), bit'($urandom_range(1, 0)));
      end
   endtask

   // driver sequence
   initial begin
      bus.start = 1'b0; bus.scalar_in = '0; bus.u_in = '0;
      bus.core_valid = 1'b0; bus.core_point_out = '0;
      test_reset();
      test_rfc_vector();
      test_clamp();
      test_latency();
      test_timeout();
      test_coincide();
      test_zero_result();
      test_ignore_core_valid();
      test_reset_mid_run();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
